// File: rtl/bcd_counter.sv
// Multi-digit packed-BCD up/down counter with built-in prescaler, parallel load and step/wrap pulses.
// Define BCD_COUNTER_SATURATE_EN to make terminal counts saturate instead of wrapping.
module bcd_counter #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1048576,
    parameter int PS_W     = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [DIGITS*4-1:0]   load_val,
    output logic [DIGITS*4-1:0]   bcd,
    output logic                  step,
    output logic                  wrap
);

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]       prescaler;
    logic                  advance;
    logic [DIGITS*4-1:0]   next_bcd;
    logic                  carry;
    logic [3:0]            cur_digit;

    // Digits above 9 are forced to 9 so the register never holds a non-BCD value.
    function automatic logic [DIGITS*4-1:0] clamp_bcd(input logic [DIGITS*4-1:0] v);
        logic [DIGITS*4-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    assign advance = en && (prescaler == PS_LAST);

    // Carry/borrow ripples through every digit in one cycle; a carry out of the
    // top digit means the whole count rolled over.
    always_comb begin
        next_bcd  = bcd;
        carry     = 1'b1;
        cur_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            cur_digit = bcd[4*i +: 4];
            if (carry) begin
                if (up) begin
                    if (cur_digit == 4'd9) begin
                        next_bcd[4*i +: 4] = 4'd0;
                    end else begin
                        next_bcd[4*i +: 4] = cur_digit + 4'd1;
                        carry              = 1'b0;
                    end
                end else begin
                    if (cur_digit == 4'd0) begin
                        next_bcd[4*i +: 4] = 4'd9;
                    end else begin
                        next_bcd[4*i +: 4] = cur_digit - 4'd1;
                        carry              = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcd       <= '0;
            prescaler <= '0;
            step      <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            step <= 1'b0;
            wrap <= 1'b0;
            if (load) begin
                bcd       <= clamp_bcd(load_val);
                prescaler <= '0;
            end else if (advance) begin
                prescaler <= '0;
                step      <= 1'b1;
`ifdef BCD_COUNTER_SATURATE_EN
                if (!carry) begin
                    bcd <= next_bcd;
                end
`else
                bcd  <= next_bcd;
                wrap <= carry;
`endif
            end else if (en) begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_counter.sv
// Self-checking bench for bcd_counter: directed scenarios plus random traffic,
// compared against an integer-valued reference model of the count and prescaler.
module tb_bcd_counter;

    localparam int DIGITS   = 4;
    localparam int PRESCALE = 3;
    localparam int PS_W     = 2;
    localparam int MAXV     = 9999;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                en = 1'b0;
    logic                up = 1'b1;
    logic                load = 1'b0;
    logic [DIGITS*4-1:0] load_val = '0;
    logic [DIGITS*4-1:0] bcd;
    logic                step;
    logic                wrap;

    int vectors     = 0;
    int miscompares = 0;
    int mVal        = 0;
    int mPs         = 0;
    logic mStep     = 1'b0;
    logic mWrap     = 1'b0;
    int stepCount   = 0;

    bcd_counter #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .PS_W(PS_W)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .bcd(bcd), .step(step), .wrap(wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [DIGITS*4-1:0] toBcd(input int v);
        logic [DIGITS*4-1:0] r;
        int rest;
        r = '0;
        rest = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(rest % 10);
            rest = rest / 10;
        end
        return r;
    endfunction

    function automatic int loadToInt(input logic [DIGITS*4-1:0] lv);
        int v, scale, d;
        v = 0;
        scale = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 9;
            v = v + d * scale;
            scale = scale * 10;
        end
        return v;
    endfunction

    // Reference model: the count is a plain integer, stepped modulo 10**DIGITS.
    task automatic modelEdge();
        mStep = 1'b0;
        mWrap = 1'b0;
        if (load) begin
            mVal = loadToInt(load_val);
            mPs  = 0;
        end else if (en) begin
            if (mPs == PRESCALE - 1) begin
                mPs   = 0;
                mStep = 1'b1;
                if (up) begin
                    if (mVal == MAXV) begin
`ifndef BCD_COUNTER_SATURATE_EN
                        mVal  = 0;
                        mWrap = 1'b1;
`endif
                    end else mVal = mVal + 1;
                end else begin
                    if (mVal == 0) begin
`ifndef BCD_COUNTER_SATURATE_EN
                        mVal  = MAXV;
                        mWrap = 1'b1;
`endif
                    end else mVal = mVal - 1;
                end
            end else begin
                mPs = mPs + 1;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        vectors++;
        assert (bcd === toBcd(mVal)) else begin
            miscompares++;
            $error("[TB] FAIL %s bcd: observed %h expected %h", tag, bcd, toBcd(mVal));
        end
        vectors++;
        assert (step === mStep) else begin
            miscompares++;
            $error("[TB] FAIL %s step: observed %b expected %b", tag, step, mStep);
        end
        vectors++;
        assert (wrap === mWrap) else begin
            miscompares++;
            $error("[TB] FAIL %s wrap: observed %b expected %b", tag, wrap, mWrap);
        end
    endtask

    task automatic checkConst(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive inputs just after an edge, take the next edge, then compare.
    task automatic applyStimulus(input logic iEn, input logic iUp, input logic iLoad,
                                 input logic [DIGITS*4-1:0] iVal, input string tag);
        en = iEn;
        up = iUp;
        load = iLoad;
        load_val = iVal;
        @(posedge clk);
        modelEdge();
        #1;
        if (step === 1'b1) stepCount++;
        checkOutput(tag);
    endtask

    initial begin
        $display("[TB] start");
        rst = 1'b0;
        #1;
        checkOutput("reset_initial");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        stepCount = 0;
        for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0, "prescale_up");
        checkConst("prescale_up_value", 32'(bcd), 32'h0010);
        checkConst("prescale_up_steps", stepCount, 10);

        applyStimulus(1'b0, 1'b1, 1'b1, 16'h9998, "load_9998");
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0, "up_wrap");
`ifdef BCD_COUNTER_SATURATE_EN
        checkConst("up_sat_value", 32'(bcd), 32'h9999);
        checkConst("up_sat_wrap", 32'(wrap), 32'h0);
`else
        checkConst("up_wrap_value", 32'(bcd), 32'h0000);
        checkConst("up_wrap_flag", 32'(wrap), 32'h1);
`endif
        applyStimulus(1'b1, 1'b1, 1'b0, '0, "after_wrap");

        applyStimulus(1'b1, 1'b0, 1'b1, 16'h1000, "load_1000");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, "down_borrow");
        checkConst("down_borrow_value", 32'(bcd), 32'h0999);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0000, "load_0000");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, "down_wrap");
`ifndef BCD_COUNTER_SATURATE_EN
        checkConst("down_wrap_value", 32'(bcd), 32'h9999);
        checkConst("down_wrap_flag", 32'(wrap), 32'h1);
`endif

        // Line the load up with an advance cycle, then check the clamped value.
        while (mPs != PRESCALE - 1) applyStimulus(1'b1, 1'b1, 1'b0, '0, "align");
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h3AF2, "load_priority");
        checkConst("load_clamp_value", 32'(bcd), 32'h3992);
        checkConst("load_no_step", 32'(step), 32'h0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0, "post_load");
        checkConst("post_load_step", 32'(step), 32'h1);

        applyStimulus(1'b1, 1'b1, 1'b0, '0, "pre_hold");
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0, "hold");
        applyStimulus(1'b1, 1'b1, 1'b0, '0, "resume_1");
        checkConst("resume_no_step", 32'(step), 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, '0, "resume_2");
        checkConst("resume_step", 32'(step), 32'h1);

        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 7) != 0), 1'($urandom),
                          ($urandom_range(0, 19) == 0), 16'($urandom), "random");
        end

        // Asynchronous reset mid-count must clear outputs before any edge.
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h4567, "pre_reset_load");
        applyStimulus(1'b1, 1'b1, 1'b0, '0, "pre_reset");
        #2;
        rst = 1'b0;
        #1;
        mVal = 0; mPs = 0; mStep = 1'b0; mWrap = 1'b0;
        checkOutput("async_reset");
        @(posedge clk);
        #1;
        checkOutput("reset_held");
        rst = 1'b1;
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'($urandom), 1'b0, '0, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
